data_mem_responder: RTL and testbench

//   Memory-side responder for the processor datapath's load/store port. Serves word

---
 rtl/data_mem_responder_if.sv | 21 ++
 rtl/data_mem_responder.sv | 129 ++++++++++++
 tb/tb_data_mem_responder.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Load/store bus between the datapath (initiator) and the data memory responder.
interface data_mem_responder_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic        busy;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ready, err, busy
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ready, err, busy
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data memory responder: word RAM plus LED/switch/cycle-counter MMIO window,
// with a fixed number of wait states and a one-cycle ready strobe.
module data_mem_responder #(
    parameter int          DEPTH_WORDS = 64,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] MMIO_BASE   = 32'h0000_0400
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus,
    input  logic [7:0]           sw_in,
    output logic [7:0]           led
);
    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  WS        = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_nx;
    logic [3:0]  cnt;
    logic [31:0] addr_q, wdata_q;
    logic        we_q;
    logic [31:0] cyc;
    logic [7:0]  sw_s1, sw_s2;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [31:0] mem [DEPTH_WORDS];

    // The access being decoded: live bus in IDLE (needed when RESP follows the
    // capture edge directly), captured copy otherwise.
    logic [31:0] acc_addr;
    logic        acc_we;
    logic        is_ram, is_led, is_sw, is_cyc, fault;
    logic [31:0] read_val;
    logic        enter_resp;
    logic        commit;

    assign acc_addr   = (state == IDLE) ? bus.addr : addr_q;
    assign acc_we     = (state == IDLE) ? bus.we   : we_q;
    assign enter_resp = (state != RESP) && (state_nx == RESP);
    assign commit     = (state == RESP) && we_q;

    // Address decode; MMIO_BASE is aligned so the equality tests imply alignment.
    always_comb begin
        is_ram   = (acc_addr[1:0] == 2'b00) && (acc_addr < RAM_BYTES);
        is_led   = (acc_addr == MMIO_BASE);
        is_sw    = (acc_addr == MMIO_BASE + 32'd4);
        is_cyc   = (acc_addr == MMIO_BASE + 32'd8);
        fault    = !(is_ram || is_led || is_sw || is_cyc);
        read_val = 32'd0;
        if (is_ram)      read_val = mem[acc_addr[AW+1:2]];
        else if (is_led) read_val = {24'd0, led};
        else if (is_sw)  read_val = {24'd0, sw_s2};
        else if (is_cyc) read_val = cyc;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (bus.req) state_nx = (WAIT_STATES > 0) ? WAIT : RESP;
            WAIT: if (cnt == 4'd1) state_nx = RESP;
            RESP: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register, request capture and wait counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            we_q    <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && bus.req) begin
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
                we_q    <= bus.we;
                cnt     <= WS;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // Response data/error registered on entry to RESP, held until the next one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else if (enter_resp) begin
            rdata_q <= (acc_we || fault) ? 32'd0 : read_val;
            err_q   <= fault;
        end
    end

    // LED register written at the edge that ends RESP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                 led <= 8'd0;
        else if (commit && is_led) led <= wdata_q[7:0];
    end

    // RAM store; contents survive reset, and reset forces IDLE so no write lands.
    always_ff @(posedge clk) begin
        if (commit && is_ram) mem[addr_q[AW+1:2]] <= wdata_q;
    end

    // Free-running cycle counter and switch synchronizer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc   <= 32'd0;
            sw_s1 <= 8'd0;
            sw_s2 <= 8'd0;
        end else begin
            cyc   <= cyc + 32'd1;
            sw_s1 <= sw_in;
            sw_s2 <= sw_s1;
        end
    end

    assign bus.ready = (state == RESP);
    assign bus.err   = err_q && (state == RESP);
    assign bus.busy  = (state != IDLE);
    assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: the driver pushes expected responses from a behavioural
// memory/MMIO model; a negedge monitor pops and compares on every ready.
module tb_data_mem_responder;
    localparam int          WS   = 2;
    localparam logic [31:0] BASE = 32'h0000_0400;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        is_cyc;
        logic [31:0] tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] sw_in = 8'd0;
    logic [7:0] led, led0;

    data_mem_responder_if bus ();
    data_mem_responder_if bus0 ();

    data_mem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(WS), .MMIO_BASE(BASE)) dut (
        .clk(clk), .rst(rst), .bus(bus), .sw_in(sw_in), .led(led));

    data_mem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(0), .MMIO_BASE(BASE)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .sw_in(sw_in), .led(led0));

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] tcyc = 0;
    exp_t        q[$];
    logic [31:0] mem_m [64];
    logic [7:0]  led_m = 8'd0;
    bit          have_prev = 0;
    logic [31:0] prev_val, prev_tag;

    always @(posedge clk) tcyc <= tcyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: address map rules applied directly to the access.
    function automatic exp_t model(input logic w, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.rdata = 32'd0; e.err = 1'b0; e.is_cyc = 1'b0; e.tag = tcyc;
        if (a % 4 != 0)        e.err = 1'b1;
        else if (a < 64 * 4) begin
            if (w) mem_m[a / 4] = d; else e.rdata = mem_m[a / 4];
        end
        else if (a == BASE)     begin if (w) led_m = d[7:0]; else e.rdata = {24'd0, led_m}; end
        else if (a == BASE + 4) begin if (!w) e.rdata = {24'd0, sw_in}; end
        else if (a == BASE + 8) begin if (!w) e.is_cyc = 1'b1; end
        else                    e.err = 1'b1;
        return e;
    endfunction

    // Monitor: compare every ready strobe against the oldest expectation.
    always @(negedge clk) begin
        if (rst && bus.ready) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_ready: got ready=1 expected no response pending");
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("err", {31'd0, bus.err}, {31'd0, e.err});
                if (e.is_cyc) begin
                    if (have_prev) chk("cyc_delta", bus.rdata - prev_val, e.tag - prev_tag);
                    have_prev = 1; prev_val = bus.rdata; prev_tag = e.tag;
                end else begin
                    chk("rdata", bus.rdata, e.rdata);
                end
            end
        end
    end

    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d, input bit scramble);
        exp_t e;
        int lat, bsy;
        bit got;
        @(negedge clk);
        chk("led", {24'd0, led}, {24'd0, led_m});
        e = model(w, a, d);
        q.push_back(e);
        bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d;
        lat = 0; bsy = 0; got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (bus.busy) bsy++;
            if (bus.ready) got = 1;
            else if (scramble) begin
                bus.addr = $urandom; bus.we = 1'($urandom); bus.wdata = $urandom;
            end
        end
        bus.req = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL timeout: got no ready expected ready within 40 cycles");
        end else begin
            chk("latency", lat, WS + 1);
            chk("busy_cycles", bsy, WS + 1);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 7))
            0, 1, 2: return 32'($urandom_range(0, 63)) * 4;
            3:       return 32'($urandom_range(0, 255)) * 4 + 32'($urandom_range(1, 3));
            4:       return 32'($urandom_range(64, 255)) * 4;
            5:       return BASE + 32'($urandom_range(0, 3)) * 4;
            6:       return BASE + 32'($urandom_range(1, 2)) * 4;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish expected finish before 300us");
        $fatal(1, "timeout");
    end

    initial begin
        bus.req = 0; bus.we = 0; bus.addr = 0; bus.wdata = 0;
        bus0.req = 0; bus0.we = 0; bus0.addr = 0; bus0.wdata = 0;
        #1 rst = 1'b0;
        #5;
        chk("rst_ready", {31'd0, bus.ready}, 0);
        chk("rst_busy",  {31'd0, bus.busy}, 0);
        chk("rst_err",   {31'd0, bus.err}, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_led",   {24'd0, led}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Fill RAM so every model word is defined.
        for (int i = 0; i < 64; i++) access(1'b1, 32'(i * 4), $urandom, 0);

        // Directed store/load, faults, and RAM word 4 intact afterwards.
        access(1'b1, 32'h10, 32'hDEADBEEF, 0);
        access(1'b0, 32'h10, 32'h0, 1);
        access(1'b0, 32'h13, 32'h0, 0);
        access(1'b0, 32'h100, 32'h0, 0);
        access(1'b1, 32'h13, 32'h12345678, 0);
        access(1'b1, 32'h100, 32'h12345678, 0);
        access(1'b0, 32'h10, 32'h0, 0);

        // MMIO: LED store, SW store ignored, SW read after sync settles.
        access(1'b1, BASE, 32'h1A5, 0);
        @(negedge clk);
        chk("led_a5", {24'd0, led}, 32'hA5);
        access(1'b1, BASE + 4, 32'hFFFF_FFFF, 0);
        sw_in = 8'h3C;
        repeat (3) @(negedge clk);
        access(1'b0, BASE + 4, 32'h0, 0);
        access(1'b0, BASE, 32'h0, 0);

        // Cycle counter deltas at several spacings.
        access(1'b0, BASE + 8, 0, 0);
        repeat (7) @(negedge clk);
        access(1'b0, BASE + 8, 0, 0);
        repeat (19) @(negedge clk);
        access(1'b0, BASE + 8, 0, 0);

        // Reset during WAIT of a store: nothing commits, outputs clear.
        @(negedge clk);
        bus.req = 1; bus.we = 1; bus.addr = 32'h20; bus.wdata = 32'h55;
        @(negedge clk);
        chk("pre_rst_busy", {31'd0, bus.busy}, 1);
        rst = 1'b0; bus.req = 0;
        #1;
        chk("mid_rst_ready", {31'd0, bus.ready}, 0);
        chk("mid_rst_busy",  {31'd0, bus.busy}, 0);
        chk("mid_rst_led",   {24'd0, led}, 0);
        chk("mid_rst_rdata", bus.rdata, 0);
        led_m = 8'd0; have_prev = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        access(1'b0, 32'h20, 32'h0, 0);

        // Randomized mix; switches only change while idle and are given time to sync.
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                sw_in = 8'($urandom);
                repeat (3) @(negedge clk);
            end
            access(1'($urandom), rand_addr(), $urandom, 1'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Zero-wait instance: req held for back-to-back loads of SW.
        sw_in = 8'h5A;
        repeat (3) @(negedge clk);
        bus0.req = 1; bus0.we = 0; bus0.addr = BASE + 4;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk("ws0_ready", {31'd0, bus0.ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
            if (bus0.ready) chk("ws0_rdata", bus0.rdata, 32'h5A);
        end
        bus0.req = 0;

        repeat (4) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
